// File: rtl/fp_align_pkg.sv
// Shared types, default widths and sizing helpers for the FP mantissa pre-alignment unit.
package fp_align_pkg;

   typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_DONE} state_e;

   localparam int MANT_W_DEF = 24;
   localparam int EXP_W_DEF  = 8;

   // Beyond this many shifts every mantissa bit, plus G and R, has left the register.
   function automatic int clamp_lim(input int mant_w);
      return mant_w + 2;
   endfunction

   function automatic int cnt_w(input int mant_w);
      return $clog2(mant_w + 3);
   endfunction

endpackage

// File: rtl/fp_align_shifter_step.sv
// One right-shift step of the alignment register; the bit leaving R folds into sticky.
module align_shift_step #(
   parameter int W = 26
) (
   input  logic [W-1:0] sh_in,
   input  logic         sticky_in,
   output logic [W-1:0] sh_out,
   output logic         sticky_out
);

   assign sh_out     = {1'b0, sh_in[W-1:1]};
   assign sticky_out = sticky_in | sh_in[0];

endmodule

// File: rtl/fp_align_shifter.sv
// Sequential pre-add alignment: pick the larger-exponent operand and right-shift the
// smaller mantissa one bit per clock, collecting guard/round/sticky.
module fp_align_shifter
   import fp_align_pkg::*;
#(
   parameter int MANT_W = MANT_W_DEF,
   parameter int EXP_W  = EXP_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [EXP_W-1:0]  exp_a,
   input  logic [EXP_W-1:0]  exp_b,
   input  logic [MANT_W-1:0] mant_a,
   input  logic [MANT_W-1:0] mant_b,
   output logic              busy,
   output logic              done,
   output logic              swapped,
   output logic [EXP_W-1:0]  exp_out,
   output logic [MANT_W-1:0] mant_big,
   output logic [MANT_W+2:0] mant_aligned
);

   localparam int SH_W  = MANT_W + 2;
   localparam int LIM   = clamp_lim(MANT_W);
   localparam int CNT_W = cnt_w(MANT_W);

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [SH_W-1:0]   sh_q, sh_d, sh_step;
   logic              sticky_q, sticky_d, sticky_step;
   logic              swapped_q, swapped_d;
   logic [EXP_W-1:0]  exp_q, exp_d;
   logic [MANT_W-1:0] big_q, big_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;

   logic              b_gt_a;
   logic [EXP_W-1:0]  diff;
   logic [CNT_W-1:0]  count_init;

   align_shift_step #(.W(SH_W)) u_step (
      .sh_in      (sh_q),
      .sticky_in  (sticky_q),
      .sh_out     (sh_step),
      .sticky_out (sticky_step)
   );

   // Ties keep A as the big operand so swapped only flags a strict B win.
   always_comb begin
      b_gt_a     = exp_b > exp_a;
      diff       = b_gt_a ? (exp_b - exp_a) : (exp_a - exp_b);
      count_init = (32'(diff) >= LIM) ? CNT_W'(LIM) : CNT_W'(diff);
   end

   always_comb begin
      state_d   = state_q;
      count_d   = count_q;
      sh_d      = sh_q;
      sticky_d  = sticky_q;
      swapped_d = swapped_q;
      exp_d     = exp_q;
      big_d     = big_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               swapped_d = b_gt_a;
               exp_d     = b_gt_a ? exp_b : exp_a;
               big_d     = b_gt_a ? mant_b : mant_a;
               sh_d      = {(b_gt_a ? mant_a : mant_b), 2'b00};
               sticky_d  = 1'b0;
               count_d   = count_init;
               state_d   = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            if (count_q != '0) begin
               sh_d     = sh_step;
               sticky_d = sticky_step;
               count_d  = count_q - CNT_W'(1);
            end else begin
               state_d = ST_DONE;
            end
         end
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
      busy_d = (state_d != ST_IDLE);
      done_d = (state_d == ST_DONE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         count_q   <= '0;
         sh_q      <= '0;
         sticky_q  <= 1'b0;
         swapped_q <= 1'b0;
         exp_q     <= '0;
         big_q     <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         count_q   <= count_d;
         sh_q      <= sh_d;
         sticky_q  <= sticky_d;
         swapped_q <= swapped_d;
         exp_q     <= exp_d;
         big_q     <= big_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   assign busy         = busy_q;
   assign done         = done_q;
   assign swapped      = swapped_q;
   assign exp_out      = exp_q;
   assign mant_big     = big_q;
   assign mant_aligned = {sh_q, sticky_q};

endmodule

// File: tb/tb_fp_align_shifter.sv
// Scoreboard bench for fp_align_shifter: constant vector table, model-checked random ops,
// and hand sequences for ignored start, back-to-back and mid-shift reset.
module tb_fp_align_shifter;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [7:0]  exp_a, exp_b;
   logic [23:0] mant_a, mant_b;
   logic        busy, done, swapped;
   logic [7:0]  exp_out;
   logic [23:0] mant_big;
   logic [26:0] mant_aligned;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   typedef struct {
      logic        sw;
      logic [7:0]  eo;
      logic [23:0] mbig;
      logic [26:0] mal;
      int          lat;
      int          start_cyc;
   } exp_t;

   typedef struct {
      logic [7:0]  ea, eb;
      logic [23:0] ma, mb;
      logic        sw;
      logic [7:0]  eo;
      logic [23:0] mbig;
      logic [26:0] mal;
      int          lat;
   } vec_t;

   exp_t sb[$];
   vec_t vecs[6];

   fp_align_shifter dut (
      .clk(clk), .rst(rst), .start(start),
      .exp_a(exp_a), .exp_b(exp_b), .mant_a(mant_a), .mant_b(mant_b),
      .busy(busy), .done(done), .swapped(swapped), .exp_out(exp_out),
      .mant_big(mant_big), .mant_aligned(mant_aligned)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Closed-form reference: one wide shift instead of bit-serial stepping.
   function automatic exp_t model(input logic [7:0] ea, input logic [7:0] eb,
                                  input logic [23:0] ma, input logic [23:0] mb);
      exp_t        e;
      int          d, n;
      logic [63:0] ext, sh;
      logic        s;
      e.sw   = (eb > ea);
      e.eo   = e.sw ? eb : ea;
      e.mbig = e.sw ? mb : ma;
      d      = e.sw ? int'(eb) - int'(ea) : int'(ea) - int'(eb);
      n      = (d > 26) ? 26 : d;
      ext    = {38'd0, (e.sw ? ma : mb), 2'b00};
      sh     = ext >> n;
      s      = |(ext & ((64'd1 << n) - 64'd1));
      e.mal  = {sh[25:0], s};
      e.lat  = n + 1;
      e.start_cyc = 0;
      return e;
   endfunction

   always @(negedge clk) begin
      if (done) begin
         if (sb.size() == 0) begin
            chk("unexpected_done", 64'(done), 64'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("swapped",      64'(swapped),      64'(e.sw));
            chk("exp_out",      64'(exp_out),      64'(e.eo));
            chk("mant_big",     64'(mant_big),     64'(e.mbig));
            chk("mant_aligned", 64'(mant_aligned), 64'(e.mal));
            chk("latency",      64'(cyc - e.start_cyc - 1), 64'(e.lat));
            chk("busy_at_done", 64'(busy),         64'd1);
         end
      end
   end

   // Drive one request at a negedge so it is sampled at the following edge (E0).
   task automatic issue(input logic [7:0] ea, input logic [7:0] eb,
                        input logic [23:0] ma, input logic [23:0] mb, input exp_t e);
      exp_t x;
      x = e;
      exp_a = ea; exp_b = eb; mant_a = ma; mant_b = mb;
      start = 1'b1;
      x.start_cyc = cyc;
      sb.push_back(x);
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   task automatic wait_done(input int budget, input bit check_idle);
      bit seen = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         chk("busy_during_op", 64'(busy), 64'd1);
         if (done) begin
            seen = 1'b1;
            break;
         end
      end
      if (!seen) chk("done_timeout", 64'd0, 64'd1);
      if (check_idle) begin
         @(negedge clk);
         chk("done_pulse_width", 64'(done), 64'd0);
         chk("busy_after_done",  64'(busy), 64'd0);
      end
   endtask

   task automatic check_zero_outputs(input string tag);
      chk({tag, "_busy"},         64'(busy),         64'd0);
      chk({tag, "_done"},         64'(done),         64'd0);
      chk({tag, "_swapped"},      64'(swapped),      64'd0);
      chk({tag, "_exp_out"},      64'(exp_out),      64'd0);
      chk({tag, "_mant_big"},     64'(mant_big),     64'd0);
      chk({tag, "_mant_aligned"}, 64'(mant_aligned), 64'd0);
   endtask

   function automatic exp_t from_vec(input vec_t v);
      exp_t e;
      e.sw = v.sw; e.eo = v.eo; e.mbig = v.mbig; e.mal = v.mal; e.lat = v.lat;
      e.start_cyc = 0;
      return e;
   endfunction

   initial begin
      exp_t e;
      vecs[0] = '{8'd130, 8'd128, 24'hC00000, 24'hA00001, 1'b0, 8'd130, 24'hC00000, 27'h1400002, 3};
      vecs[1] = '{8'd127, 8'd127, 24'h800000, 24'hFFFFFF, 1'b0, 8'd127, 24'h800000, 27'h7FFFFF8, 1};
      vecs[2] = '{8'd100, 8'd103, 24'h80000F, 24'h900000, 1'b1, 8'd103, 24'h900000, 27'h080000F, 4};
      vecs[3] = '{8'd200, 8'd1,   24'h812345, 24'h800000, 1'b0, 8'd200, 24'h812345, 27'h0000001, 27};
      vecs[4] = '{8'd10,  8'd36,  24'hFFFFFF, 24'hABCDEF, 1'b1, 8'd36,  24'hABCDEF, 27'h0000001, 27};
      vecs[5] = '{8'd50,  8'd25,  24'h800000, 24'hC00000, 1'b0, 8'd50,  24'h800000, 27'h0000003, 26};

      rst = 1'b1; start = 1'b0;
      exp_a = '0; exp_b = '0; mant_a = '0; mant_b = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_zero_outputs("reset");
      rst = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 6; i++) begin
         issue(vecs[i].ea, vecs[i].eb, vecs[i].ma, vecs[i].mb, from_vec(vecs[i]));
         wait_done(40, 1'b1);
         @(negedge clk);
      end

      // Random operands including wide exponent gaps, checked against the closed-form model.
      for (int i = 0; i < 8; i++) begin
         logic [7:0]  ea, eb;
         logic [23:0] ma, mb;
         ea = 8'($urandom_range(0, 255));
         eb = (i < 4) ? 8'(int'(ea) ^ $urandom_range(0, 31)) : 8'($urandom_range(0, 255));
         ma = 24'($urandom) | 24'h800000;
         mb = 24'($urandom) | 24'h800000;
         issue(ea, eb, ma, mb, model(ea, eb, ma, mb));
         wait_done(40, 1'b1);
         @(negedge clk);
      end

      // start pulsed mid-shift must be dropped: exactly one result, no second op.
      issue(vecs[2].ea, vecs[2].eb, vecs[2].ma, vecs[2].mb, from_vec(vecs[2]));
      @(negedge clk);
      exp_a = 8'd7; exp_b = 8'd90; mant_a = 24'h123456; mant_b = 24'h654321;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done(40, 1'b1);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("ignored_start_idle", 64'(busy), 64'd0);
      end
      chk("ignored_start_sb_empty", 64'(sb.size()), 64'd0);

      // Back-to-back: start held through DONE is taken in the following IDLE cycle.
      exp_a = 8'd130; exp_b = 8'd128; mant_a = 24'hC00000; mant_b = 24'hA00001;
      start = 1'b1;
      e = from_vec(vecs[0]);
      e.start_cyc = cyc;
      sb.push_back(e);
      wait_done(40, 1'b0);
      exp_a = 8'd100; exp_b = 8'd103; mant_a = 24'h80000F; mant_b = 24'h900000;
      @(negedge clk);
      chk("b2b_idle_gap_busy", 64'(busy), 64'd0);
      e = from_vec(vecs[2]);
      e.start_cyc = cyc;
      sb.push_back(e);
      @(posedge clk);
      #1 start = 1'b0;
      wait_done(40, 1'b1);
      @(negedge clk);

      // Reset mid-shift clears everything at once and the next op is clean.
      issue(vecs[4].ea, vecs[4].eb, vecs[4].ma, vecs[4].mb, from_vec(vecs[4]));
      repeat (5) @(negedge clk);
      chk("pre_reset_busy", 64'(busy), 64'd1);
      rst = 1'b1;
      #1;
      check_zero_outputs("midshift_reset");
      sb.delete();
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      issue(vecs[0].ea, vecs[0].eb, vecs[0].ma, vecs[0].mb, from_vec(vecs[0]));
      wait_done(40, 1'b1);
      repeat (2) @(negedge clk);
      chk("final_sb_empty", 64'(sb.size()), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
